// File: rtl/adc_serial_responder_pkg.sv
// Shared acoustics front-end definitions: ADC frame geometry and the responder state type.
package acoustics_pkg;

  localparam int ADC_WORD_SIZE   = 10;
  localparam int ADC_LEAD_ZEROS  = 3;
  localparam int ADC_TRAIL_ZEROS = 3;
  localparam int ADC_FRAME_BITS  = ADC_LEAD_ZEROS + ADC_WORD_SIZE + ADC_TRAIL_ZEROS;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    DATA,
    TRAIL,
    WAIT_CS_HIGH
  } resp_state_t;

endpackage

// File: rtl/adc_serial_responder_if.sv
// Sample handshake and serial frame signals between the ADC responder and its host/receiver.
interface adc_serial_responder_if
  import acoustics_pkg::*;
#(
  parameter int WORD_SIZE = ADC_WORD_SIZE
);

  logic                 cs;
  logic [WORD_SIZE-1:0] sample_in;
  logic                 sample_valid;
  logic                 sample_ready;
  logic                 sdata;
  logic                 busy;
  logic                 frame_done;

  modport master (
    output cs, sample_in, sample_valid,
    input  sample_ready, sdata, busy, frame_done
  );

  modport slave (
    input  cs, sample_in, sample_valid,
    output sample_ready, sdata, busy, frame_done
  );

endinterface

// File: rtl/adc_serial_responder_frame_bit_counter.sv
// Loadable up-counter with clear and terminal-count compare, used to time each frame phase.
module frame_bit_counter
  import acoustics_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] terminal_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == terminal_i);

endmodule

// File: rtl/adc_serial_responder.sv
// Serial ADC responder: sends one held sample MSB-first per cs-low frame, wrapped in zero bits.
// Optional RAMP_GEN_EN replaces the sample handshake with an incrementing test ramp.
module adc_serial_responder
  import acoustics_pkg::*;
#(
  parameter int WORD_SIZE   = ADC_WORD_SIZE,
  parameter int LEAD_ZEROS  = ADC_LEAD_ZEROS,
  parameter int TRAIL_ZEROS = ADC_TRAIL_ZEROS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  adc_serial_responder_if.slave  bus
);

  localparam int CNT_W = $clog2(LEAD_ZEROS + WORD_SIZE + TRAIL_ZEROS + 1);
  localparam logic [CNT_W-1:0] LEAD_LAST  = CNT_W'(LEAD_ZEROS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(WORD_SIZE - 1);
  localparam logic [CNT_W-1:0] TRAIL_LAST = CNT_W'(TRAIL_ZEROS - 1);

  resp_state_t          state_q, state_d;
  logic [WORD_SIZE-1:0] hold_q, hold_d;
  logic [WORD_SIZE-1:0] shift_q, shift_d;
  logic                 sdata_q, sdata_d;
  logic                 done_q, done_d;
  logic [CNT_W-1:0]     terminal;
  logic [CNT_W-1:0]     count;
  logic                 tc;
  logic                 cnt_clear;
  logic                 cnt_en;
  logic                 handshake;
  logic                 sample_ready;

`ifdef RAMP_GEN_EN
  localparam logic [WORD_SIZE-1:0] RAMP_STEP = WORD_SIZE'(1);
  assign sample_ready = 1'b0;
  assign handshake    = 1'b0;
`else
  assign sample_ready = (state_q == IDLE);
  assign handshake    = bus.sample_valid && sample_ready;
`endif

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    shift_d  = shift_q;
    sdata_d  = 1'b0;
    done_d   = 1'b0;
    terminal = '0;

`ifndef RAMP_GEN_EN
    if (handshake) begin
      hold_d = bus.sample_in;
    end
`endif

    case (state_q)
      IDLE: begin
        if (!bus.cs) begin
          state_d = LEAD;
          shift_d = handshake ? bus.sample_in : hold_q;
        end
      end
      LEAD: begin
        terminal = LEAD_LAST;
        if (bus.cs) begin
          state_d = IDLE;
        end else if (tc) begin
          state_d = DATA;
          sdata_d = shift_q[WORD_SIZE-1];
          shift_d = {shift_q[WORD_SIZE-2:0], 1'b0};
        end
      end
      DATA: begin
        terminal = DATA_LAST;
        if (bus.cs) begin
          state_d = IDLE;
        end else if (tc) begin
          state_d = TRAIL;
        end else begin
          sdata_d = shift_q[WORD_SIZE-1];
          shift_d = {shift_q[WORD_SIZE-2:0], 1'b0};
        end
      end
      TRAIL: begin
        terminal = TRAIL_LAST;
        if (bus.cs) begin
          state_d = IDLE;
        end else if (tc) begin
          state_d = WAIT_CS_HIGH;
          done_d  = 1'b1;
`ifdef RAMP_GEN_EN
          hold_d  = hold_q + RAMP_STEP;
`endif
        end
      end
      WAIT_CS_HIGH: begin
        if (bus.cs) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The phase counter restarts on every state change so each phase counts from zero.
  assign cnt_clear = (state_d != state_q);
  assign cnt_en    = (state_q == LEAD) || (state_q == DATA) || (state_q == TRAIL);

  frame_bit_counter #(
    .WIDTH (CNT_W)
  ) u_frame_bit_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (cnt_clear),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (cnt_en),
    .terminal_i (terminal),
    .count_o    (count),
    .tc_o       (tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      shift_q <= '0;
      sdata_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      shift_q <= shift_d;
      sdata_q <= sdata_d;
      done_q  <= done_d;
    end
  end

  assign bus.sample_ready = sample_ready;
  assign bus.sdata        = sdata_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.frame_done   = done_q;

endmodule

// File: tb/tb_adc_serial_responder.sv
// Directed self-checking bench for adc_serial_responder in its default (handshake) build.
module tb_adc_serial_responder;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  adc_serial_responder_if #(.WORD_SIZE(10)) bus ();

  adc_serial_responder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic loadSample(input logic [9:0] val);
    bus.sample_in    = val;
    bus.sample_valid = 1'b1;
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
  endtask

  // Holds cs low for lowCycles edges (first one is edge k), recording what the receiver would see.
  task automatic runFrame(input int lowCycles, output logic [15:0] bits, output int doneCount,
                          output int doneIdx, output int lateOnes, output int busyLow,
                          output int readyHigh);
    bits = '0; doneCount = 0; doneIdx = -1; lateOnes = 0; busyLow = 0; readyHigh = 0;
    bus.cs = 1'b0;
    for (int i = 0; i < lowCycles; i++) begin
      @(posedge clk); #1;
      bus.sample_valid = 1'b0;
      if (i < 16) bits[15-i] = bus.sdata;
      else if (bus.sdata) lateOnes++;
      if (bus.frame_done) begin doneCount++; doneIdx = i; end
      if (!bus.busy) busyLow++;
      if (bus.sample_ready) readyHigh++;
    end
    bus.cs = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cs = 1'b1; bus.sample_valid = 1'b0; bus.sample_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.sdata !== 1'b0) begin errors++; $display("[TB] FAIL reset_sdata got %b expected 0", bus.sdata); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", bus.busy); end
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b expected 0", bus.frame_done); end
    checks++; if (bus.sample_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b expected 1", bus.sample_ready); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_frame();
    logic [15:0] bits; int dc, di, lo, bl, rh;
    logic [15:0] expBits = {3'b000, 10'h2A5, 3'b000};
    loadSample(10'h2A5);
    runFrame(20, bits, dc, di, lo, bl, rh);
    checks++; if (bits !== expBits) begin errors++; $display("[TB] FAIL basic_bits got %b expected %b", bits, expBits); end
    checks++; if (dc !== 1) begin errors++; $display("[TB] FAIL basic_done_count got %0d expected 1", dc); end
    checks++; if (di !== 16) begin errors++; $display("[TB] FAIL basic_done_edge got %0d expected 16", di); end
    checks++; if (lo !== 0) begin errors++; $display("[TB] FAIL basic_late_ones got %0d expected 0", lo); end
    checks++; if (bl !== 0) begin errors++; $display("[TB] FAIL basic_busy_low got %0d expected 0", bl); end
  endtask

  task automatic test_hold_cs_low();
    logic [15:0] bits; int dc, di, lo, bl, rh;
    logic [15:0] expBits = {3'b000, 10'h2A5, 3'b000};
    runFrame(30, bits, dc, di, lo, bl, rh);
    checks++; if (bits !== expBits) begin errors++; $display("[TB] FAIL hold_bits got %b expected %b", bits, expBits); end
    checks++; if (dc !== 1) begin errors++; $display("[TB] FAIL hold_done_count got %0d expected 1", dc); end
    checks++; if (lo !== 0) begin errors++; $display("[TB] FAIL hold_late_ones got %0d expected 0", lo); end
    checks++; if (rh !== 0) begin errors++; $display("[TB] FAIL hold_ready_while_low got %0d expected 0", rh); end
    checks++; if (bus.sample_ready !== 1'b1) begin errors++; $display("[TB] FAIL hold_ready_after got %b expected 1", bus.sample_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL hold_busy_after got %b expected 0", bus.busy); end
  endtask

  task automatic test_abort();
    logic [15:0] bits; int dc, di, lo, bl, rh;
    logic [10:0] seen = '0;
    logic [10:0] expSeen = {3'b000, 8'hFF};
    int lateDone = 0;
    logic [15:0] expBits = {3'b000, 10'h3FF, 3'b000};
    loadSample(10'h3FF);
    bus.cs = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      seen[10-i] = bus.sdata;
    end
    bus.cs = 1'b1;
    @(posedge clk); #1;
    checks++; if (seen !== expSeen) begin errors++; $display("[TB] FAIL abort_partial got %b expected %b", seen, expSeen); end
    checks++; if (bus.sdata !== 1'b0) begin errors++; $display("[TB] FAIL abort_sdata got %b expected 0", bus.sdata); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got %b expected 0", bus.busy); end
    checks++; if (bus.sample_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_ready got %b expected 1", bus.sample_ready); end
    if (bus.frame_done) lateDone++;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.frame_done) lateDone++;
    end
    checks++; if (lateDone !== 0) begin errors++; $display("[TB] FAIL abort_no_done got %0d expected 0", lateDone); end
    runFrame(20, bits, dc, di, lo, bl, rh);
    checks++; if (bits !== expBits) begin errors++; $display("[TB] FAIL abort_resend got %b expected %b", bits, expBits); end
    checks++; if (dc !== 1) begin errors++; $display("[TB] FAIL abort_resend_done got %0d expected 1", dc); end
  endtask

  task automatic test_bypass();
    logic [15:0] bits; int dc, di, lo, bl, rh;
    logic [15:0] expBits = {3'b000, 10'h155, 3'b000};
    loadSample(10'h001);
    bus.sample_in = 10'h155;
    bus.sample_valid = 1'b1;
    runFrame(20, bits, dc, di, lo, bl, rh);
    checks++; if (bits !== expBits) begin errors++; $display("[TB] FAIL bypass_bits got %b expected %b", bits, expBits); end
    runFrame(20, bits, dc, di, lo, bl, rh);
    checks++; if (bits !== expBits) begin errors++; $display("[TB] FAIL bypass_held got %b expected %b", bits, expBits); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] bits; int dc, di, lo, bl, rh;
    logic [15:0] expBits = {3'b000, 10'h0CC, 3'b000};
    loadSample(10'h0CC);
    runFrame(17, bits, dc, di, lo, bl, rh);
    checks++; if (bits !== expBits) begin errors++; $display("[TB] FAIL b2b_first got %b expected %b", bits, expBits); end
    runFrame(17, bits, dc, di, lo, bl, rh);
    checks++; if (bits !== expBits) begin errors++; $display("[TB] FAIL b2b_second got %b expected %b", bits, expBits); end
    checks++; if (di !== 16) begin errors++; $display("[TB] FAIL b2b_done_edge got %0d expected 16", di); end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] bits; int dc, di, lo, bl, rh;
    logic [15:0] expBits = 16'h0000;
    loadSample(10'h3FF);
    bus.cs = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.cs = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.sdata !== 1'b0) begin errors++; $display("[TB] FAIL midrst_sdata got %b expected 0", bus.sdata); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got %b expected 0", bus.busy); end
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_done got %b expected 0", bus.frame_done); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.sample_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ready got %b expected 1", bus.sample_ready); end
    runFrame(20, bits, dc, di, lo, bl, rh);
    checks++; if (bits !== expBits) begin errors++; $display("[TB] FAIL midrst_hold_cleared got %b expected %b", bits, expBits); end
    checks++; if (dc !== 1) begin errors++; $display("[TB] FAIL midrst_done_count got %0d expected 1", dc); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_hold_cs_low();
    test_abort();
    test_bypass();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
